message_scheduler: RTL and testbench

- Sequences the six-digit HEX message display for the game FSM.
- Game FSM posts message requests (message code + level) through a valid/ready handshake into a small FIFO.
- The block drives state_number/level_number of the message decoder, shows each queued message for a fixed dwell time, then inserts a blank gap.
- Sits between the game controller and the message decoder. It owns all message timing, so the game FSM never waits on the display.

---
 rtl/message_scheduler_if.sv | 11 +
 rtl/message_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_message_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/message_scheduler_if.sv
// rtl/message_scheduler_if.sv - request handshake bundle between game FSM and message scheduler
interface message_scheduler_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_state;
  logic [3:0] req_level;
  logic       req_blink;

  modport master (output req_valid, req_state, req_level, req_blink, input req_ready);
  modport slave  (input req_valid, req_state, req_level, req_blink, output req_ready);
endinterface

// File: rtl/message_scheduler.sv
// rtl/message_scheduler.sv - queued HEX message sequencer with dwell/gap timing; MSG_BLINK_EN adds per-message blink
module message_scheduler #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES   = 5_000_000,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic                clk,
  input  logic                resetn,
  message_scheduler_if.slave  req,
  input  logic                hold,
  input  logic                flush,
  output logic [3:0]          state_number,
  output logic [3:0]          level_number,
  output logic                busy,
  output logic                msg_done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [3:0]  BLANK    = 4'hF;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  disp_q, disp_d;
  logic [3:0]  lvl_q, lvl_d;
  logic        done_q, done_d;

  logic [3:0]  st_mem_q [DEPTH];
  logic [3:0]  lv_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, push, pop;

  // Ready is gated by flush so a request offered alongside a flush is never taken.
  assign full          = (count_q == FULL_CNT);
  assign req.req_ready = resetn & ~full & ~flush;
  assign push          = req.req_valid & req.req_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      st_mem_q[wr_ptr_q] <= req.req_state;
      lv_mem_q[wr_ptr_q] <= req.req_level;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef MSG_BLINK_EN
  logic        bl_mem_q [DEPTH];
  logic        cur_blink_q, cur_blink_d;
  logic        boff_q, boff_d;
  logic [31:0] bcnt_q, bcnt_d;

  always_ff @(posedge clk) begin
    if (push) bl_mem_q[wr_ptr_q] <= req.req_blink;
  end
`else
  logic unused_blink;
  assign unused_blink = req.req_blink;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    lvl_d   = lvl_q;
    done_d  = 1'b0;
    pop     = 1'b0;
`ifdef MSG_BLINK_EN
    cur_blink_d = cur_blink_q;
    boff_d      = boff_q;
    bcnt_d      = bcnt_q;
`endif
    case (state_q)
      IDLE: if (count_q != '0) pop = 1'b1;
      SHOW: begin
        if (!hold) begin
`ifdef MSG_BLINK_EN
          if (bcnt_q == 32'(BLINK_CYCLES - 1)) begin
            bcnt_d = '0;
            boff_d = ~boff_q;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
`endif
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = 32'(GAP_CYCLES - 1);
            disp_d  = BLANK;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (count_q != '0) pop = 1'b1;
          else               state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = SHOW;
      cnt_d   = 32'(DWELL_CYCLES - 1);
      disp_d  = st_mem_q[rd_ptr_q];
      lvl_d   = lv_mem_q[rd_ptr_q];
`ifdef MSG_BLINK_EN
      cur_blink_d = bl_mem_q[rd_ptr_q];
      boff_d      = 1'b0;
      bcnt_d      = '0;
`endif
    end
    // Flush overrides everything above, including a pop or a dwell expiry this cycle.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      disp_d  = BLANK;
      done_d  = 1'b0;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      disp_q  <= BLANK;
      lvl_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      lvl_q   <= lvl_d;
      done_q  <= done_d;
    end
  end

`ifdef MSG_BLINK_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_blink_q <= 1'b0;
      boff_q      <= 1'b0;
      bcnt_q      <= '0;
    end else begin
      cur_blink_q <= cur_blink_d;
      boff_q      <= boff_d;
      bcnt_q      <= bcnt_d;
    end
  end

  assign state_number = (state_q == SHOW && cur_blink_q && boff_q) ? BLANK : disp_q;
`else
  assign state_number = disp_q;
`endif

  assign level_number = lvl_q;
  assign msg_done     = done_q;
  assign busy         = (state_q != IDLE) | (count_q != '0);

endmodule

// File: tb/tb_message_scheduler.sv
// tb/tb_message_scheduler.sv - directed self-checking bench for message_scheduler
module tb_message_scheduler;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] state_number, level_number;
  logic       busy, msg_done;
  int         n_checks = 0;
  int         n_fail = 0;

  message_scheduler_if rif();

  message_scheduler #(
    .DWELL_CYCLES(4), .GAP_CYCLES(2), .DEPTH(4), .BLINK_CYCLES(3)
  ) dut (
    .clk(clk), .resetn(resetn), .req(rif.slave), .hold(hold), .flush(flush),
    .state_number(state_number), .level_number(level_number),
    .busy(busy), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    rif.req_valid = 1'b0;
    rif.req_state = 4'h0;
    rif.req_level = 4'h0;
    rif.req_blink = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset;
    drive_idle();
    resetn = 1'b0;
    step();
    step();
    n_checks++; if (state_number !== 4'hF) begin n_fail++; $display("FAIL reset_state got %h want F", state_number); end
    n_checks++; if (level_number !== 4'h0) begin n_fail++; $display("FAIL reset_level got %h want 0", level_number); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (msg_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", msg_done); end
    n_checks++; if (rif.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_reset got %b want 0", rif.req_ready); end
    resetn = 1'b1;
    step();
    n_checks++; if (rif.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b want 1", rif.req_ready); end
    n_checks++; if (state_number !== 4'hF) begin n_fail++; $display("FAIL reset_state_after got %h want F", state_number); end
  endtask

  task automatic test_single;
    logic [3:0] exp_st;
    drive_idle();
    rif.req_valid = 1'b1;
    rif.req_state = 4'h2;
    rif.req_level = 4'h3;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) rif.req_valid = 1'b0;
      exp_st = (k >= 1 && k <= 4) ? 4'h2 : 4'hF;
      n_checks++; if (state_number !== exp_st) begin n_fail++; $display("FAIL single_state k=%0d got %h want %h", k, state_number, exp_st); end
      if (k >= 1 && k <= 4) begin
        n_checks++; if (level_number !== 4'h3) begin n_fail++; $display("FAIL single_level k=%0d got %h want 3", k, level_number); end
      end
      n_checks++; if (msg_done !== (k == 5)) begin n_fail++; $display("FAIL single_done k=%0d got %b want %b", k, msg_done, (k == 5)); end
      n_checks++; if (busy !== (k < 7)) begin n_fail++; $display("FAIL single_busy k=%0d got %b want %b", k, busy, (k < 7)); end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] codes [3];
    logic [3:0] exp_st;
    int         dones;
    codes[0] = 4'h0; codes[1] = 4'h6; codes[2] = 4'h7;
    dones = 0;
    drive_idle();
    for (int k = 0; k < 20; k++) begin
      if (k < 3) begin
        rif.req_valid = 1'b1;
        rif.req_state = codes[k];
      end else begin
        rif.req_valid = 1'b0;
      end
      step();
      exp_st = 4'hF;
      if (k >= 1 && k <= 4)   exp_st = 4'h0;
      if (k >= 7 && k <= 10)  exp_st = 4'h6;
      if (k >= 13 && k <= 16) exp_st = 4'h7;
      n_checks++; if (state_number !== exp_st) begin n_fail++; $display("FAIL b2b_state k=%0d got %h want %h", k, state_number, exp_st); end
      if (msg_done === 1'b1) dones++;
    end
    n_checks++; if (dones != 3) begin n_fail++; $display("FAIL b2b_done_count got %0d want 3", dones); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got %b want 0", busy); end
  endtask

  task automatic test_full;
    logic [3:0] codes [6];
    logic [3:0] lvls  [6];
    int         dones;
    codes[0] = 4'h3; codes[1] = 4'h0; codes[2] = 4'h2; codes[3] = 4'h6; codes[4] = 4'h7; codes[5] = 4'h3;
    lvls[0]  = 4'h1; lvls[1]  = 4'h2; lvls[2]  = 4'h5; lvls[3]  = 4'h4; lvls[4]  = 4'h6; lvls[5]  = 4'h9;
    dones = 0;
    drive_idle();
    for (int k = 0; k < 39; k++) begin
      rif.req_valid = 1'b0;
      if (k == 0) begin
        rif.req_valid = 1'b1; rif.req_state = codes[0]; rif.req_level = lvls[0];
      end else if (k >= 2 && k <= 5) begin
        rif.req_valid = 1'b1; rif.req_state = codes[k-1]; rif.req_level = lvls[k-1];
      end else if (k >= 6 && k <= 8) begin
        rif.req_valid = 1'b1; rif.req_state = codes[5]; rif.req_level = lvls[5];
      end
      step();
      if (msg_done === 1'b1) dones++;
      if (k == 5 || k == 6) begin
        n_checks++; if (rif.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low k=%0d got %b want 0", k, rif.req_ready); end
      end
      if (k == 7) begin
        n_checks++; if (rif.req_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise got %b want 1", rif.req_ready); end
      end
      if (k == 8) begin
        n_checks++; if (rif.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_refull got %b want 0", rif.req_ready); end
      end
      if (k == 1 || k == 7 || k == 13 || k == 19 || k == 25 || k == 31) begin
        n_checks++; if (state_number !== codes[(k-1)/6]) begin n_fail++; $display("FAIL full_order_state k=%0d got %h want %h", k, state_number, codes[(k-1)/6]); end
        n_checks++; if (level_number !== lvls[(k-1)/6]) begin n_fail++; $display("FAIL full_order_level k=%0d got %h want %h", k, level_number, lvls[(k-1)/6]); end
      end
    end
    n_checks++; if (dones != 6) begin n_fail++; $display("FAIL full_done_count got %0d want 6", dones); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end got %b want 0", busy); end
  endtask

  task automatic test_hold;
    logic [3:0] exp_st;
    drive_idle();
    for (int k = 0; k < 11; k++) begin
      rif.req_valid = (k == 0);
      rif.req_state = 4'h6;
      rif.req_level = 4'h1;
      hold = (k >= 2 && k <= 4) || (k >= 9 && k <= 10);
      step();
      exp_st = (k >= 1 && k <= 7) ? 4'h6 : 4'hF;
      n_checks++; if (state_number !== exp_st) begin n_fail++; $display("FAIL hold_state k=%0d got %h want %h", k, state_number, exp_st); end
      n_checks++; if (msg_done !== (k == 8)) begin n_fail++; $display("FAIL hold_done k=%0d got %b want %b", k, msg_done, (k == 8)); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_gap_busy got %b want 0", busy); end
    drive_idle();
  endtask

  task automatic test_flush;
    logic [3:0] codes [3];
    codes[0] = 4'h7; codes[1] = 4'h0; codes[2] = 4'h3;
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      rif.req_valid = 1'b1;
      rif.req_state = codes[k];
      step();
    end
    n_checks++; if (state_number !== 4'h7) begin n_fail++; $display("FAIL flush_pre_state got %h want 7", state_number); end
    flush = 1'b1;
    rif.req_valid = 1'b1;
    rif.req_state = 4'h2;
    #1;
    n_checks++; if (rif.req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", rif.req_ready); end
    step();
    flush = 1'b0;
    rif.req_valid = 1'b0;
    n_checks++; if (state_number !== 4'hF) begin n_fail++; $display("FAIL flush_state got %h want F", state_number); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
    n_checks++; if (msg_done !== 1'b0) begin n_fail++; $display("FAIL flush_done got %b want 0", msg_done); end
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++; if (state_number !== 4'hF || busy !== 1'b0 || msg_done !== 1'b0) begin
        n_fail++; $display("FAIL flush_quiet k=%0d got st=%h busy=%b done=%b want F/0/0", k, state_number, busy, msg_done);
      end
    end
    rif.req_valid = 1'b1;
    rif.req_state = 4'h2;
    rif.req_level = 4'h4;
    step();
    rif.req_valid = 1'b0;
    step();
    n_checks++; if (state_number !== 4'h2) begin n_fail++; $display("FAIL flush_recover_state got %h want 2", state_number); end
    n_checks++; if (level_number !== 4'h4) begin n_fail++; $display("FAIL flush_recover_level got %h want 4", level_number); end
    for (int k = 0; k < 6; k++) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_recover_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_hold();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
